gf_poly_div_io: RTL and testbench

GF_POLY_DIV_IO -- requirements
Module: gf_poly_div_io

---
 rtl/gf_poly_div_io.sv | 238 +++++++++++++++++++++++
 tb/tb_gf_poly_div_io.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/gf_poly_div_io.sv
// Serial wrapper for a combinational GF(2^4) polynomial divider: 1 beat/cycle in, quotient out 2 cycles after last beat.
// No backpressure; a dropped in_valid mid-frame aborts it. GF_DIV_ZERO_CHK_EN forces an all-zero quotient for a zero divisor.

module Division_IP #(
   parameter int IP_WIDTH = 7
) (
   input  logic [IP_WIDTH*4-1:0] dividend_i,
   input  logic [IP_WIDTH*4-1:0] divisor_i,
   output logic [IP_WIDTH*4-1:0] quotient_o
);

   // Exponent form in/out, 4'hf = zero; nibble i carries the x^i coefficient.
   // Field polynomial x^4 + x + 1, primitive element alpha = 4'h2.
   function automatic logic [3:0] exp2vec(input logic [3:0] e);
      logic [3:0] v;
      case (e)
         4'd0:    v = 4'h1;
         4'd1:    v = 4'h2;
         4'd2:    v = 4'h4;
         4'd3:    v = 4'h8;
         4'd4:    v = 4'h3;
         4'd5:    v = 4'h6;
         4'd6:    v = 4'hc;
         4'd7:    v = 4'hb;
         4'd8:    v = 4'h5;
         4'd9:    v = 4'ha;
         4'd10:   v = 4'h7;
         4'd11:   v = 4'he;
         4'd12:   v = 4'hf;
         4'd13:   v = 4'hd;
         4'd14:   v = 4'h9;
         default: v = 4'h0;
      endcase
      return v;
   endfunction

   function automatic logic [3:0] vec2exp(input logic [3:0] v);
      logic [3:0] e;
      case (v)
         4'h1:    e = 4'd0;
         4'h2:    e = 4'd1;
         4'h4:    e = 4'd2;
         4'h8:    e = 4'd3;
         4'h3:    e = 4'd4;
         4'h6:    e = 4'd5;
         4'hc:    e = 4'd6;
         4'hb:    e = 4'd7;
         4'h5:    e = 4'd8;
         4'ha:    e = 4'd9;
         4'h7:    e = 4'd10;
         4'he:    e = 4'd11;
         4'hf:    e = 4'd12;
         4'hd:    e = 4'd13;
         4'h9:    e = 4'd14;
         default: e = 4'hf;
      endcase
      return e;
   endfunction

   function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] p;
      logic [3:0] aa;
      p  = 4'h0;
      aa = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
      end
      return p;
   endfunction

   logic [3:0] rem  [IP_WIDTH];
   logic [3:0] dv   [IP_WIDTH];
   logic [3:0] qv   [IP_WIDTH];
   logic [3:0] lead_e;
   logic [3:0] lead_inv;
   logic [3:0] t;
   logic       found;
   int         deg;

   always_comb begin
      deg      = 0;
      found    = 1'b0;
      lead_e   = 4'hf;
      t        = 4'h0;
      for (int i = 0; i < IP_WIDTH; i++) begin
         rem[i] = exp2vec(dividend_i[i*4 +: 4]);
         dv[i]  = exp2vec(divisor_i[i*4 +: 4]);
         qv[i]  = 4'h0;
      end
      for (int i = 0; i < IP_WIDTH; i++) begin
         if (divisor_i[i*4 +: 4] != 4'hf) begin
            deg    = i;
            found  = 1'b1;
            lead_e = divisor_i[i*4 +: 4];
         end
      end
      lead_inv = exp2vec((lead_e == 4'd0) ? 4'd0 : 4'd15 - lead_e);
      // A zero divisor has no pivot and leaves the quotient at zero.
      for (int s = IP_WIDTH - 1; s >= 0; s--) begin
         if (found && (s + deg < IP_WIDTH)) begin
            t = 4'h0;
            for (int k = 0; k < IP_WIDTH; k++) begin
               if (k == s + deg) t = gmul(rem[k], lead_inv);
            end
            qv[s] = t;
            for (int j = 0; j < IP_WIDTH; j++) begin
               if ((j <= deg) && (s + j < IP_WIDTH)) rem[s+j] = rem[s+j] ^ gmul(t, dv[j]);
            end
         end
      end
      quotient_o = '1;
      for (int i = 0; i < IP_WIDTH; i++) begin
         quotient_o[i*4 +: 4] = vec2exp(qv[i]);
      end
   end

endmodule

module gf_poly_div_io #(
   parameter int IP_WIDTH = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [3:0] in_dividend,
   input  logic [3:0] in_divisor,
   output logic       out_valid,
   output logic [3:0] out_quotient
);

   localparam int OPW = IP_WIDTH * 4;
   localparam int CW  = $clog2(IP_WIDTH + 1);
   localparam logic [OPW-1:0] ALL_F = '1;
   localparam logic [CW-1:0]  LAST  = CW'(IP_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [OPW-1:0] dvd_q, dvd_d;
   logic [OPW-1:0] dvs_q, dvs_d;
   logic [OPW-1:0] quo_q, quo_d;
   logic [OPW-1:0] ip_quo;
   logic [OPW-1:0] calc_quo;

   Division_IP #(.IP_WIDTH(IP_WIDTH)) u_div (
      .dividend_i (dvd_q),
      .divisor_i  (dvs_q),
      .quotient_o (ip_quo)
   );

`ifdef GF_DIV_ZERO_CHK_EN
   assign calc_quo = (dvs_q == ALL_F) ? ALL_F : ip_quo;
`else
   assign calc_quo = ip_quo;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // First beat lands in the low nibble; later beats push it toward the MSB.
               dvd_d = (ALL_F << 4) | OPW'(in_dividend);
               dvs_d = (ALL_F << 4) | OPW'(in_divisor);
               if (IP_WIDTH == 1) begin
                  state_d = CALC;
                  cnt_d   = '0;
               end else begin
                  state_d = LOAD;
                  cnt_d   = CW'(1);
               end
            end
         end
         LOAD: begin
            if (in_valid) begin
               dvd_d = (dvd_q << 4) | OPW'(in_dividend);
               dvs_d = (dvs_q << 4) | OPW'(in_divisor);
               if (cnt_q == LAST) begin
                  state_d = CALC;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               state_d = IDLE;
               cnt_d   = '0;
               dvd_d   = ALL_F;
               dvs_d   = ALL_F;
            end
         end
         CALC: begin
            quo_d   = calc_quo;
            state_d = OUT;
            cnt_d   = '0;
         end
         OUT: begin
            quo_d = (quo_q << 4) | OPW'(4'hf);
            if (cnt_q == LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= ALL_F;
         dvs_q   <= ALL_F;
         quo_q   <= ALL_F;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
      end
   end

   // Outputs decode straight from state so reset silences them without waiting for a clock.
   assign out_valid    = (state_q == OUT);
   assign out_quotient = out_valid ? quo_q[OPW-1 -: 4] : 4'h0;

endmodule

// File: tb/tb_gf_poly_div_io.sv
// Directed bench for gf_poly_div_io at IP_WIDTH=7: latency, abort, reset and zero-divisor cases.
module tb_gf_poly_div_io;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] in_dividend;
   logic [3:0] in_divisor;
   logic       out_valid;
   logic [3:0] out_quotient;

   int n_checks;
   int n_errors;

   gf_poly_div_io #(.IP_WIDTH(7)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_dividend  (in_dividend),
      .in_divisor   (in_divisor),
      .out_valid    (out_valid),
      .out_quotient (out_quotient)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference divider using log/antilog arithmetic; nibble i = x^i coefficient.
   function automatic logic [3:0] alog(input int e);
      logic [4:0] v;
      v = 5'h1;
      for (int k = 0; k < 15; k++) begin
         if (k < e) begin
            v = v << 1;
            if (v[4]) v = v ^ 5'h13;
         end
      end
      return v[3:0];
   endfunction

   function automatic int vlog(input logic [3:0] v);
      int r;
      r = -1;
      for (int k = 0; k < 15; k++) if (alog(k) == v) r = k;
      return r;
   endfunction

   function automatic logic [27:0] model_div(input logic [27:0] a, input logic [27:0] b);
      logic [3:0]  rem [7];
      logic [3:0]  dv  [7];
      logic [27:0] q;
      int          dg;
      int          qe;
      q  = '1;
      dg = -1;
      for (int i = 0; i < 7; i++) begin
         rem[i] = (a[i*4 +: 4] == 4'hf) ? 4'h0 : alog(int'(a[i*4 +: 4]));
         dv[i]  = (b[i*4 +: 4] == 4'hf) ? 4'h0 : alog(int'(b[i*4 +: 4]));
         if (b[i*4 +: 4] != 4'hf) dg = i;
      end
      if (dg < 0) return q;
      for (int s = 6; s >= 0; s--) begin
         if (s + dg <= 6 && rem[s+dg] != 4'h0) begin
            qe = (vlog(rem[s+dg]) - vlog(dv[dg]) + 15) % 15;
            q[s*4 +: 4] = 4'(qe);
            for (int j = 0; j <= dg; j++) begin
               if (dv[j] != 4'h0) rem[s+j] = rem[s+j] ^ alog((qe + vlog(dv[j])) % 15);
            end
         end
      end
      return q;
   endfunction

   // Beat 0 is the top nibble of each 28-bit word; leaves in_valid low one negedge after the last beat.
   task automatic send_frame(input logic [27:0] dvd, input logic [27:0] dvs, input int beats);
      for (int i = 0; i < beats; i++) begin
         @(negedge clk);
         in_valid    = 1'b1;
         in_dividend = dvd[27-4*i -: 4];
         in_divisor  = dvs[27-4*i -: 4];
      end
      @(negedge clk);
      in_valid    = 1'b0;
      in_dividend = 4'h0;
      in_divisor  = 4'h0;
   endtask

   task automatic recv(input string tag, input logic [27:0] exp);
      check({tag, "_calc_vld"}, 32'(out_valid), 32'd0);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check({tag, "_vld"}, 32'(out_valid), 32'd1);
         check({tag, "_q"}, 32'(out_quotient), 32'(exp[27-4*i -: 4]));
      end
      @(negedge clk);
      check({tag, "_end_vld"}, 32'(out_valid), 32'd0);
      check({tag, "_end_q"}, 32'(out_quotient), 32'd0);
   endtask

   task automatic quiet(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (out_valid || out_quotient != 4'h0) seen++;
      end
      check(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [27:0] exp_zero;
      n_checks    = 0;
      n_errors    = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_dividend = 4'h0;
      in_divisor  = 4'h0;
      repeat (3) @(negedge clk);
      check("rst_vld", 32'(out_valid), 32'd0);
      check("rst_q", 32'(out_quotient), 32'd0);
      rst_n = 1'b1;
      quiet("idle_quiet", 3);

      send_frame(28'h0123456, 28'hffffff0, 7);
      recv("div_by_one", 28'h0123456);

      send_frame(28'hffff372, 28'hffff372, 7);
      recv("self_div", 28'hffffff0);

      send_frame(28'hfffff25, 28'hfff0111, 7);
      recv("deg_gt", 28'hfffffff);

      send_frame(28'hffff0f0, 28'hfffff00, 7);
      recv("sq_div", 28'hfffff00);

      send_frame(28'h5a3e1c7, 28'hfff4e20, 7);
      recv("model_vec", model_div(28'h5a3e1c7, 28'hfff4e20));

      send_frame(28'h0123456, 28'hffffff0, 4);
      quiet("partial_quiet", 12);
      send_frame(28'h0123456, 28'hffffff0, 7);
      recv("after_partial", 28'h0123456);
      quiet("after_partial_quiet", 10);

      send_frame(28'h0123456, 28'hffffff0, 7);
      check("mid_calc_vld", 32'(out_valid), 32'd0);
      repeat (3) @(negedge clk);
      check("mid_beat3_vld", 32'(out_valid), 32'd1);
      check("mid_beat3_q", 32'(out_quotient), 32'd2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_vld", 32'(out_valid), 32'd0);
      check("mid_rst_q", 32'(out_quotient), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      quiet("post_rst_quiet", 12);
      send_frame(28'hffff372, 28'hffff372, 7);
      recv("post_rst_frame", 28'hffffff0);

`ifdef GF_DIV_ZERO_CHK_EN
      exp_zero = 28'hfffffff;
`else
      exp_zero = model_div(28'h0000000, 28'hfffffff);
`endif
      send_frame(28'h0000000, 28'hfffffff, 7);
      recv("zero_div", exp_zero);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
